// File: rtl/song_sequencer.sv
// song_sequencer: beat-driven melody reader; walks a song ROM and holds
// each entry's note for its programmed number of tempo beats.
//
// Parameters:
//   SONG_LEN - ROM depth in entries (last address SONG_LEN-1)
//   ADDR_W   - ROM address width, 2**ADDR_W >= SONG_LEN
//   NOTE_W   - note code width, code 0 is a rest
//   DUR_W    - duration field width, in beats
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   beat       - one-cycle tempo strobe
//   start/stop - one-cycle playback control pulses
//   loop_en    - restart at address 0 at end of song
//   rom_addr   - ROM read address (registered)
//   rom_data   - ROM word {note, duration}, valid one cycle after rom_addr
//   note       - current note code
//   note_on    - non-rest note sounding
//   playing    - sequencer not idle
//   done       - one-cycle pulse on natural end of song without looping
module song_sequencer #(
    parameter int SONG_LEN = 32,
    parameter int ADDR_W   = 5,
    parameter int NOTE_W   = 5,
    parameter int DUR_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_on,
    output logic                    playing,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    state_t            r_state;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [NOTE_W-1:0] r_note;
    logic              r_note_on;
    logic              r_playing;
    logic              r_done;

    logic [NOTE_W-1:0] w_rom_note;
    logic [DUR_W-1:0]  w_rom_dur;
    logic              w_last_beat;
    logic              w_end;

    assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = rom_data[DUR_W-1:0];

    // Final beat of the entry currently being held.
    assign w_last_beat = (r_state == HOLD) && beat &&
                         (r_dur_cnt == DUR_W'(1));

    // End of song: an end marker (zero duration) in LOAD, or the last
    // beat of the final ROM address.
    assign w_end = ((r_state == LOAD) && (w_rom_dur == '0)) ||
                   (w_last_beat && (r_addr == LAST_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dur_cnt <= '0;
            r_addr    <= '0;
            r_note    <= '0;
            r_note_on <= 1'b0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state   <= IDLE;
                r_addr    <= '0;
                r_note    <= '0;
                r_note_on <= 1'b0;
                r_playing <= 1'b0;
            end else if (w_end) begin
                if (loop_en) begin
                    // Note keeps sounding across the wrap.
                    r_addr  <= '0;
                    r_state <= FETCH;
                end else begin
                    r_done    <= 1'b1;
                    r_note    <= '0;
                    r_note_on <= 1'b0;
                    r_playing <= 1'b0;
                    r_state   <= IDLE;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_addr    <= '0;
                            r_playing <= 1'b1;
                            r_state   <= FETCH;
                        end
                    end
                    FETCH: r_state <= LOAD;
                    LOAD: begin
                        r_note    <= w_rom_note;
                        r_note_on <= (w_rom_note != '0);
                        r_dur_cnt <= w_rom_dur;
                        r_state   <= HOLD;
                    end
                    HOLD: begin
                        if (w_last_beat) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= FETCH;
                        end else if (beat) begin
                            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rom_addr = r_addr;
    assign note     = r_note;
    assign note_on  = r_note_on;
    assign playing  = r_playing;
    assign done     = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench for song_sequencer with a 4-entry
// synchronous ROM model; table-driven basic song plus corner sequences.
module tb_song_sequencer;

    localparam int SONG_LEN = 4;
    localparam int ADDR_W   = 5;
    localparam int NOTE_W   = 5;
    localparam int DUR_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              beat, start, stop, loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [NOTE_W-1:0] note;
    logic              note_on, playing, done;

    logic [7:0] rom [0:31];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       b, s, p;
        logic [4:0] addr;
        logic [4:0] nt;
        logic       on, play, dn, chk_addr;
    } vec_t;

    vec_t tbl [0:16];

    song_sequencer #(
        .SONG_LEN(SONG_LEN),
        .ADDR_W  (ADDR_W),
        .NOTE_W  (NOTE_W),
        .DUR_W   (DUR_W)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .beat    (beat),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note    (note),
        .note_on (note_on),
        .playing (playing),
        .done    (done)
    );

    always #10 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic vec_t mk(logic b, logic s, logic p, int a, int n,
                                logic on, logic pl, logic dn, logic ca);
        vec_t v;
        v.b = b; v.s = s; v.p = p;
        v.addr = 5'(a); v.nt = 5'(n);
        v.on = on; v.play = pl; v.dn = dn; v.chk_addr = ca;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input int a, input int n,
                              input logic on, input logic pl,
                              input logic dn, input logic ca);
        if (ca) chk({name, ".rom_addr"}, int'(rom_addr), a);
        chk({name, ".note"}, int'(note), n);
        chk({name, ".note_on"}, int'(note_on), int'(on));
        chk({name, ".playing"}, int'(playing), int'(pl));
        chk({name, ".done"}, int'(done), int'(dn));
    endtask

    task automatic step(input logic b, input logic s, input logic p);
        @(negedge clk);
        beat = b; start = s; stop = p;
        @(posedge clk);
        #1;
        beat = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic load_basic();
        rom[0] = {5'd5, 3'd2};
        rom[1] = {5'd0, 3'd1};
        rom[2] = {5'd9, 3'd3};
        rom[3] = {5'd0, 3'd0};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        load_basic();
        rst_n = 1'b0; beat = 1'b0; start = 1'b0; stop = 1'b0;
        loop_en = 1'b0;

        // Basic song, one vector per clock; checked after the edge.
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[2]  = mk(1, 0, 0, 0, 5, 1, 1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 5, 1, 1, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 5, 1, 1, 0, 1);
        tbl[5]  = mk(1, 0, 0, 1, 5, 1, 1, 0, 1);
        tbl[6]  = mk(1, 0, 0, 1, 5, 1, 1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 1);
        tbl[8]  = mk(1, 0, 0, 2, 0, 0, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 2, 0, 0, 1, 0, 1);
        tbl[10] = mk(1, 0, 0, 2, 9, 1, 1, 0, 1);
        tbl[11] = mk(1, 0, 0, 2, 9, 1, 1, 0, 1);
        tbl[12] = mk(1, 0, 0, 2, 9, 1, 1, 0, 1);
        tbl[13] = mk(1, 0, 0, 3, 9, 1, 1, 0, 1);
        tbl[14] = mk(0, 0, 0, 3, 9, 1, 1, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        expect_out("idle_after_reset", 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].b, tbl[i].s, tbl[i].p);
            expect_out($sformatf("basic%0d", i), int'(tbl[i].addr),
                       int'(tbl[i].nt), tbl[i].on, tbl[i].play,
                       tbl[i].dn, tbl[i].chk_addr);
        end

        // Stop beats start in the same cycle.
        step(0, 1, 1);
        expect_out("start_stop", 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        expect_out("start_stop_idle", 0, 0, 0, 0, 0, 1);

        // Loop and wrap: every entry {3,1}, address 3 is the last one.
        for (int i = 0; i < 4; i++) rom[i] = {5'd3, 3'd1};
        loop_en = 1'b1;
        step(0, 1, 0);
        expect_out("loop_fetch0", 0, 0, 0, 1, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        expect_out("loop_hold0", 0, 3, 1, 1, 0, 1);
        for (int k = 1; k < 10; k++) begin
            step(1, 0, 0);
            expect_out($sformatf("loop_fetch%0d", k), k % 4, 3, 1, 1, 0, 1);
            step(0, 0, 0);
            expect_out($sformatf("loop_load%0d", k), k % 4, 3, 1, 1, 0, 1);
            step(0, 0, 0);
            expect_out($sformatf("loop_hold%0d", k), k % 4, 3, 1, 1, 0, 1);
        end

        // Stop mid-HOLD: immediate idle, no done.
        step(0, 0, 1);
        expect_out("stop_hold", 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        expect_out("stop_after", 0, 0, 0, 0, 0, 1);
        loop_en = 1'b0;

        // End marker at address 0.
        rom[0] = {5'd7, 3'd0};
        step(0, 1, 0);
        expect_out("marker_t1", 0, 0, 0, 1, 0, 1);
        step(0, 0, 0);
        expect_out("marker_t2", 0, 0, 0, 1, 0, 1);
        step(0, 0, 0);
        expect_out("marker_t3", 0, 0, 0, 0, 1, 0);
        step(0, 0, 0);
        expect_out("marker_t4", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while holding the third entry.
        load_basic();
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        expect_out("pre_reset", 2, 9, 1, 1, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        expect_out("post_reset1", 0, 0, 0, 0, 0, 1);
        step(1, 0, 0);
        expect_out("post_reset2", 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Beat-driven melody reader for the electronic piano. Consumes the one-cycle 4 Hz `beat` strobe from the tempo generator, walks a song ROM entry by entry, and holds each entry's note for its programmed number of beats. The note code it presents feeds the tone-divider/speaker path in place of the keyboard.

## Interface
- `SONG_LEN`, 32: ROM depth in entries; the last address is `SONG_LEN-1`.
- `ADDR_W`, 5: ROM address width; must satisfy `2**ADDR_W >= SONG_LEN`.
- `NOTE_W`, 5: note code width; code 0 means rest.
- `DUR_W`, 3: duration field width, in beats.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `beat` in 1: tempo strobe, high for one `clk` cycle per beat.
- `start` in 1: one-cycle pulse; begins playback from address 0.
- `stop` in 1: one-cycle pulse; aborts playback.
- `loop_en` in 1: level; when 1, playback restarts at address 0 at end of song.
- `rom_addr` out ADDR_W: ROM read address.
- `rom_data` in NOTE_W+DUR_W: ROM word, valid one cycle after `rom_addr`.
  - Bits `[NOTE_W+DUR_W-1:DUR_W]` are the note.
  - Bits `[DUR_W-1:0]` are the duration.
- `note` out NOTE_W: current note code.
- `note_on` out 1: 1 while a non-rest note is sounding.
- `playing` out 1: 1 in every state except IDLE.
- `done` out 1: one-cycle pulse on natural end of song when `loop_en` is 0.

## Operation
States: IDLE, FETCH, LOAD, HOLD.

- **IDLE**
  - `start` moves to FETCH and sets `rom_addr` to 0.
  - `note` and `note_on` read 0.
- **FETCH**
  - Single wait cycle to cover ROM latency.
  - Always moves to LOAD.
- **LOAD**
  - Samples `rom_data`.
  - If duration is 0, the entry is an end marker: go to the end-of-song action.
  - Otherwise:
    - `note` <= note field.
    - `note_on` <= (note field != 0).
    - `dur_cnt` <= duration.
    - Move to HOLD.
- **HOLD**
  - Each `beat` decrements `dur_cnt`.
  - On a `beat` with `dur_cnt == 1`:
    - If `rom_addr == SONG_LEN-1`, take the end-of-song action.
    - Otherwise `rom_addr` <= `rom_addr+1` and move to FETCH.
- **End-of-song action**
  - If `loop_en` is 1: `rom_addr` <= 0 and move to FETCH. `note` and `note_on` keep their values, and `done` stays 0.
  - If `loop_en` is 0: `done` pulses high for 1 cycle, `note` <= 0, `note_on` <= 0, and move to IDLE.
  - `loop_en` is sampled in the cycle the action is taken.
- `note` and `note_on` stay unchanged through FETCH/LOAD between entries, so there is no audible gap; they change only in LOAD.
- `stop`, from any state:
  - Next state IDLE, `note`/`note_on` cleared, `rom_addr` <= 0.
  - No `done` pulse.
- `stop` and `start` in the same cycle: `stop` wins and the block stays or goes IDLE.
- `start` outside IDLE is ignored.
- `beat` in IDLE, FETCH or LOAD is ignored. A note's duration counts only the strobes seen in HOLD.
- `dur_cnt` is DUR_W bits wide and is never decremented below 1 (it is only loaded with a nonzero value).

## Timing
- Reset values: `rom_addr`=0, `note`=0, `note_on`=0, `playing`=0, `done`=0, state IDLE, `dur_cnt`=0.
- Reset asserted mid-song takes effect immediately (asynchronous) and forces all reset values.
- `start` at cycle T:
  - T+1: FETCH, `playing`=1.
  - T+2: LOAD.
  - T+3: `note`/`note_on` valid.
- Inter-entry overhead: the final `beat` of an entry in cycle T gives the new note at T+3.
- `done` is registered. It is high in the single cycle in which the state reads IDLE and `note_on` reads 0.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-HOLD -> all outputs 0 within the same cycle; after release stays IDLE until `start`.
- **Basic song:** ROM {note 5 dur 2, note 0 dur 1, note 9 dur 3, end marker}; `start`, then `beat` every 20 cycles ->
  - `note`=5 with `note_on`=1 for 2 beats;
  - `note`=0 with `note_on`=0 for 1 beat;
  - `note`=9 for 3 beats;
  - then a single `done` pulse and `playing`=0.
- **Loop and wrap:** `SONG_LEN`=4, all entries {note 3 dur 1}, `loop_en`=1 ->
  - `rom_addr` sequence 0,1,2,3,0,1…;
  - `done` never asserted; `note_on` stays 1 continuously.
- **Stop precedence:** `start` and `stop` in the same cycle in IDLE -> stays IDLE. `stop` mid-HOLD -> IDLE next cycle, `note_on`=0, no `done`.
- **Ignored beats and starts:** `beat` pulse coincident with LOAD -> `dur_cnt` unaffected, and a dur 2 note lasts 2 further beats. `start` during HOLD -> no change to `rom_addr` or `note`.
- **End marker at address 0:** ROM[0] has dur 0 and `loop_en`=0 -> `done` pulses 3 cycles after `start`, and `note_on` never asserts.
